// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter: level requests with
// per-requester data in, registered grant/owner/busy and register contents out.
interface shared_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [IW-1:0]  owner;
  logic           busy;
  logic [W-1:0]   q;

  modport master (output req, wdata, input gnt, owner, busy, q);
  modport slave  (input req, wdata, output gnt, owner, busy, q);
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register between N requesters.
// Tenure is bounded to MAX_HOLD writes and always ends with an idle cycle.
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  shared_reg_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q,   gnt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q,  last_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic [W-1:0]  q_q,     q_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          own_req;
  logic          at_max;

  // Scan starts one past the last grantee so the previous owner ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_q) + k) % N;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  assign own_req = bus.req[owner_q];
  assign at_max  = (hold_q == HW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IW'(N - 1);
      hold_q  <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = N'(1) << win_idx;
          owner_d = win_idx;
          last_d  = win_idx;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (own_req) begin
          q_d = bus.wdata[owner_q*W +: W];
        end
        // Forced release still commits the final write above.
        if (!own_req || at_max) begin
          state_d = IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt   = gnt_q;
    bus.owner = owner_q;
    bus.busy  = (state_q == GRANT);
    bus.q     = q_q;
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench: per-cycle vector table plus a short hand sequence,
// expected outputs queued at drive time and compared after the edge.
module tb_shared_reg_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] q;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];
  vec_t sb[$];

  shared_reg_arbiter_if #(.N(N), .W(W)) bus ();

  shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] o, input logic b, input logic [7:0] qv);
    vec_t v;
    v.rst = r; v.req = rq; v.gnt = g; v.owner = o; v.busy = b; v.q = qv;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input logic [N*W-1:0] wd, input int idx);
    vec_t e;
    @(negedge clk);
    rst       = v.rst;
    bus.req   = v.req;
    bus.wdata = wd;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt",   idx, 32'(bus.gnt),   32'(e.gnt));
    chk("owner", idx, 32'(bus.owner), 32'(e.owner));
    chk("busy",  idx, 32'(bus.busy),  32'(e.busy));
    chk("q",     idx, 32'(bus.q),     32'(e.q));
  endtask

  initial begin
    logic [N*W-1:0] wd;
    vec_t v;
    rst       = 1'b1;
    bus.req   = '0;
    bus.wdata = '0;

    // Lane i in row r carries data i*64 + r, so expected q = owner*64 + row.
    add(1, 4'b0000, 4'b0000, 0, 0, 8'd0);             // 0 reset
    add(0, 4'b0000, 4'b0000, 0, 0, 8'd0);             // 1 idle
    add(0, 4'b1111, 4'b0001, 0, 1, 8'd0);             // 2 grant 0
    add(0, 4'b1111, 4'b0001, 0, 1, 8'd3);
    add(0, 4'b1111, 4'b0001, 0, 1, 8'd4);
    add(0, 4'b1111, 4'b0001, 0, 1, 8'd5);
    add(0, 4'b1111, 4'b0000, 0, 0, 8'd6);             // 6 timeout
    add(0, 4'b1111, 4'b0010, 1, 1, 8'd6);             // 7 grant 1
    add(0, 4'b1111, 4'b0010, 1, 1, 8'(64+8));
    add(0, 4'b1111, 4'b0010, 1, 1, 8'(64+9));
    add(0, 4'b1111, 4'b0010, 1, 1, 8'(64+10));
    add(0, 4'b1111, 4'b0000, 1, 0, 8'(64+11));
    add(0, 4'b1111, 4'b0100, 2, 1, 8'(64+11));        // 12 grant 2
    add(0, 4'b1111, 4'b0100, 2, 1, 8'(128+13));
    add(0, 4'b1111, 4'b0100, 2, 1, 8'(128+14));
    add(0, 4'b1111, 4'b0100, 2, 1, 8'(128+15));
    add(0, 4'b1111, 4'b0000, 2, 0, 8'(128+16));
    add(0, 4'b1111, 4'b1000, 3, 1, 8'(128+16));       // 17 grant 3
    add(0, 4'b1111, 4'b1000, 3, 1, 8'(192+18));
    add(0, 4'b1111, 4'b1000, 3, 1, 8'(192+19));
    add(0, 4'b1111, 4'b1000, 3, 1, 8'(192+20));
    add(0, 4'b1111, 4'b0000, 3, 0, 8'(192+21));
    add(0, 4'b1111, 4'b0001, 0, 1, 8'(192+21));       // 22 grant 0 again
    add(0, 4'b1111, 4'b0001, 0, 1, 8'd23);
    add(0, 4'b1111, 4'b0001, 0, 1, 8'd24);
    add(0, 4'b1110, 4'b0000, 0, 0, 8'd24);            // 25 early drop, no write
    add(0, 4'b0000, 4'b0000, 0, 0, 8'd24);
    add(0, 4'b1000, 4'b1000, 3, 1, 8'd24);            // 27 last := 3
    add(0, 4'b0000, 4'b0000, 3, 0, 8'd24);
    add(0, 4'b1010, 4'b0010, 1, 1, 8'd24);            // 29 wrap -> 1
    add(0, 4'b0000, 4'b0000, 1, 0, 8'd24);
    add(0, 4'b1010, 4'b1000, 3, 1, 8'd24);            // 31 skip -> 3
    add(0, 4'b0000, 4'b0000, 3, 0, 8'd24);
    add(0, 4'b1010, 4'b0010, 1, 1, 8'd24);            // 33 wrap -> 1
    add(0, 4'b0010, 4'b0010, 1, 1, 8'(64+34));
    add(0, 4'b0000, 4'b0000, 1, 0, 8'(64+34));
    add(0, 4'b1111, 4'b0100, 2, 1, 8'(64+34));        // 36 grant 2
    add(0, 4'b1111, 4'b0100, 2, 1, 8'(128+37));
    add(0, 4'b1111, 4'b0100, 2, 1, 8'(128+38));
    add(1, 4'b1111, 4'b0000, 0, 0, 8'd0);             // 39 reset mid-grant
    add(0, 4'b1111, 4'b0001, 0, 1, 8'd0);             // 40 requester 0 first
    add(0, 4'b1111, 4'b0001, 0, 1, 8'd41);
    add(0, 4'b0000, 4'b0000, 0, 0, 8'd41);
    add(0, 4'b0010, 4'b0010, 1, 1, 8'd41);            // 43 lone requester 1
    add(0, 4'b0010, 4'b0010, 1, 1, 8'(64+44));
    add(0, 4'b0010, 4'b0010, 1, 1, 8'(64+45));
    add(0, 4'b0010, 4'b0010, 1, 1, 8'(64+46));
    add(0, 4'b0010, 4'b0000, 1, 0, 8'(64+47));        // 47 timeout
    add(0, 4'b0010, 4'b0010, 1, 1, 8'(64+47));        // 48 re-grant
    add(0, 4'b0010, 4'b0010, 1, 1, 8'(64+49));
    add(0, 4'b0010, 4'b0010, 1, 1, 8'(64+50));
    add(0, 4'b0010, 4'b0010, 1, 1, 8'(64+51));
    add(0, 4'b0010, 4'b0000, 1, 0, 8'(64+52));
    add(0, 4'b0000, 4'b0000, 1, 0, 8'(64+52));

    for (int r = 0; r < tbl.size(); r++) begin
      wd = '0;
      for (int i = 0; i < N; i++) wd[i*W +: W] = 8'(i*64 + r);
      apply(tbl[r], wd, r);
    end

    // Single requester with specific data values.
    wd = '0;
    wd[2*W +: W] = 8'hA5;
    v.rst = 0; v.req = 4'b0100; v.gnt = 4'b0100; v.owner = 2; v.busy = 1; v.q = 8'(64+52);
    apply(v, wd, 100);
    v.q = 8'hA5;
    apply(v, wd, 101);
    wd[2*W +: W] = 8'h3C;
    v.q = 8'h3C;
    apply(v, wd, 102);
    v.req = 4'b0000; v.gnt = 4'b0000; v.busy = 0;
    apply(v, wd, 103);
    apply(v, wd, 104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
